// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
// Extends a raw immediate field to a wider word according to a 2-bit mode.
// The result is registered behind a valid/ready handshake. Storage is one
// main output register plus one skid register, so in_ready comes from a flop
// and does not depend on out_ready.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   upstream offers an immediate
//   in_ready   block can accept an immediate this cycle (registered)
//   in_imm     raw immediate, IN_W bits
//   in_mode    00 sign, 01 zero, 10 upper, 11 branch (sign-extend then << 2)
//   out_valid  out_data holds a valid result
//   out_ready  downstream consumes out_data this cycle
//   out_data   extended result, OUT_W bits
//   acc_count  number of accepted inputs, modulo 2^CNT_W
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] acc_count
);

  // Extension rules; branch mode is the sign-extended value times four,
  // truncated to OUT_W bits.
  function automatic logic [OUT_W-1:0] extend_imm(input logic [IN_W-1:0] imm,
                                                  input logic [1:0]      mode);
    logic [OUT_W-1:0] sext;
    sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    case (mode)
      2'b00:   extend_imm = sext;
      2'b01:   extend_imm = {{(OUT_W-IN_W){1'b0}}, imm};
      2'b10:   extend_imm = {imm, {(OUT_W-IN_W){1'b0}}};
      2'b11:   extend_imm = {sext[OUT_W-3:0], 2'b00};
      default: extend_imm = sext;
    endcase
  endfunction

  logic [OUT_W-1:0] main_r;
  logic             main_valid_r;
  logic [OUT_W-1:0] skid_r;
  logic             skid_full_r;
  logic             in_ready_r;
  logic [CNT_W-1:0] acc_r;

  logic [OUT_W-1:0] main_nxt_s;
  logic             main_valid_nxt_s;
  logic [OUT_W-1:0] skid_nxt_s;
  logic             skid_full_nxt_s;
  logic [CNT_W-1:0] acc_nxt_s;
  logic [OUT_W-1:0] result_s;
  logic             in_fire_s;
  logic             out_fire_s;

  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = main_valid_r & out_ready;
  assign result_s   = extend_imm(in_imm, in_mode);

  // Next-state for main/skid storage and the acceptance counter.
  // An input can never arrive while skid is full, because in_ready is low then.
  always_comb begin
    main_nxt_s       = main_r;
    main_valid_nxt_s = main_valid_r;
    skid_nxt_s       = skid_r;
    skid_full_nxt_s  = skid_full_r;
    acc_nxt_s        = acc_r;
    if (out_fire_s) begin
      if (skid_full_r) begin
        main_nxt_s      = skid_r;
        skid_full_nxt_s = 1'b0;
      end else if (in_fire_s) begin
        main_nxt_s       = result_s;
        main_valid_nxt_s = 1'b1;
      end else begin
        main_valid_nxt_s = 1'b0;
      end
    end else if (in_fire_s) begin
      if (main_valid_r) begin
        skid_nxt_s      = result_s;
        skid_full_nxt_s = 1'b1;
      end else begin
        main_nxt_s       = result_s;
        main_valid_nxt_s = 1'b1;
      end
    end else begin
      main_valid_nxt_s = main_valid_r;
    end
    if (in_fire_s) begin
      acc_nxt_s = acc_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      acc_nxt_s = acc_r;
    end
  end

  // State registers; in_ready is held low through reset and rises on the
  // first edge afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_r       <= {OUT_W{1'b0}};
      main_valid_r <= 1'b0;
      skid_r       <= {OUT_W{1'b0}};
      skid_full_r  <= 1'b0;
      in_ready_r   <= 1'b0;
      acc_r        <= {CNT_W{1'b0}};
    end else begin
      main_r       <= main_nxt_s;
      main_valid_r <= main_valid_nxt_s;
      skid_r       <= skid_nxt_s;
      skid_full_r  <= skid_full_nxt_s;
      in_ready_r   <= ~skid_full_nxt_s;
      acc_r        <= acc_nxt_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = main_valid_r;
  assign out_data  = main_r;
  assign acc_count = acc_r;

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  acc_count;

  logic        in_valid2;
  logic        in_ready2;
  logic [11:0] in_imm2;
  logic [1:0]  in_mode2;
  logic        out_valid2;
  logic        out_ready2;
  logic [19:0] out_data2;
  logic [7:0]  acc_count2;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state: results held inside the block, in order
  logic [31:0] model_q[$];
  int          model_cnt = 0;
  bit          ready_up  = 1'b0;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .acc_count(acc_count)
  );

  imm_extend_pipe #(.IN_W(12), .OUT_W(20), .CNT_W(8)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_imm(in_imm2), .in_mode(in_mode2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_data(out_data2), .acc_count(acc_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic statement of the extension rules.
  function automatic longint unsigned model_ext(input int in_w, input int out_w,
                                                input longint unsigned imm,
                                                input int mode);
    longint unsigned mod_in, mod_out;
    longint          sval;
    mod_in  = 64'd1 << in_w;
    mod_out = 64'd1 << out_w;
    if (imm >= mod_in / 64'd2) sval = longint'(imm) - longint'(mod_in);
    else sval = longint'(imm);
    case (mode)
      0:       return longint'(sval) & longint'(mod_out - 64'd1);
      1:       return imm;
      2:       return (imm * (mod_out / mod_in)) % mod_out;
      3:       return longint'(sval * 4) & longint'(mod_out - 64'd1);
      default: return 64'd0;
    endcase
  endfunction

  // One clock cycle on the main instance: drive, clock, update model, settle.
  task automatic step(input bit iv, input logic [15:0] imm, input logic [1:0] md,
                      input bit ordy);
    bit acc, ofire;
    longint unsigned r;
    in_valid  = iv;
    in_imm    = imm;
    in_mode   = md;
    out_ready = ordy;
    acc   = iv && ready_up && (model_q.size() < 2);
    ofire = (model_q.size() > 0) && ordy;
    r     = model_ext(16, 32, 64'(imm), int'(md));
    @(posedge clk);
    if (ofire) void'(model_q.pop_front());
    if (acc) begin
      model_q.push_back(r[31:0]);
      model_cnt = (model_cnt + 1) % 256;
    end
    ready_up = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_imm = 16'h0; in_mode = 2'b00; out_ready = 1'b0;
    in_valid2 = 1'b0; in_imm2 = 12'h0; in_mode2 = 2'b00; out_ready2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || acc_count !== 8'h0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b data=%h cnt=%0d rdy=%b, want 0/0/0/0",
               out_valid, out_data, acc_count, in_ready);
    end
    rst = 1'b0;
    ready_up = 1'b0;
    step(1'b0, 16'h0, 2'b00, 1'b0);
    n_checks++;
    if (in_ready !== 1'b1 || in_ready2 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b/%b, want 1/1", in_ready, in_ready2);
    end
  endtask

  task automatic test_modes();
    logic [31:0] exp8004 [4];
    logic [31:0] got;
    exp8004[0] = 32'hFFFF8004; exp8004[1] = 32'h00008004;
    exp8004[2] = 32'h80040000; exp8004[3] = 32'hFFFE0010;
    for (int m = 0; m < 4; m++) begin
      step(1'b1, 16'h8004, 2'(m), 1'b1);
      got = out_data;
      n_checks++;
      if (out_valid !== 1'b1 || got !== exp8004[m] || model_q[0] !== exp8004[m]) begin
        n_fail++;
        $display("FAIL mode_8004_m%0d: got valid=%b data=%h, want 1 %h", m, out_valid, got, exp8004[m]);
      end
    end
    step(1'b1, 16'h7FFF, 2'b00, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h00007FFF) begin
      n_fail++;
      $display("FAIL mode_7fff_sign: got %b %h, want 1 00007fff", out_valid, out_data);
    end
    step(1'b1, 16'h7FFF, 2'b11, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0001FFFC) begin
      n_fail++;
      $display("FAIL mode_7fff_branch: got %b %h, want 1 0001fffc", out_valid, out_data);
    end
    step(1'b0, 16'hFFFF, 2'b10, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_after_modes: got valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_skid();
    int c0;
    c0 = model_cnt;
    step(1'b1, 16'h0001, 2'b01, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL skid_a_loaded: got %b %h rdy=%b, want 1 00000001 1", out_valid, out_data, in_ready);
    end
    step(1'b1, 16'h0002, 2'b01, 1'b0);
    n_checks++;
    if (out_data !== 32'h1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL skid_b_taken: got data=%h rdy=%b, want 00000001 0", out_data, in_ready);
    end
    step(1'b1, 16'h0003, 2'b01, 1'b0);
    n_checks++;
    if (out_data !== 32'h1 || in_ready !== 1'b0 || acc_count !== 8'((c0 + 2) % 256)) begin
      n_fail++;
      $display("FAIL skid_third_stalls: got data=%h rdy=%b cnt=%0d, want 00000001 0 %0d",
               out_data, in_ready, acc_count, (c0 + 2) % 256);
    end
    step(1'b0, 16'h0003, 2'b01, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h2 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL skid_b_out: got %b %h rdy=%b, want 1 00000002 1", out_valid, out_data, in_ready);
    end
    step(1'b0, 16'h0, 2'b00, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL skid_drained: got valid=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_random();
    logic [15:0] imm;
    logic [1:0]  md;
    bit          iv, ordy;
    for (int i = 0; i < 400; i++) begin
      imm  = 16'($urandom);
      md   = 2'($urandom_range(0, 3));
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      step(iv, imm, md, ordy);
      n_checks++;
      if (out_valid !== (model_q.size() > 0) || in_ready !== (model_q.size() < 2) ||
          acc_count !== 8'(model_cnt) ||
          (model_q.size() > 0 && out_data !== model_q[0])) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got v=%b d=%h r=%b c=%0d, want v=%b d=%h r=%b c=%0d",
                 i, out_valid, out_data, in_ready, acc_count, model_q.size() > 0,
                 (model_q.size() > 0) ? model_q[0] : 32'h0, model_q.size() < 2, model_cnt);
      end
    end
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 2'b00, 1'b1);
  endtask

  task automatic test_back_to_back();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_q.delete();
    model_cnt = 0;
    ready_up = 1'b0;
    step(1'b0, 16'h0, 2'b00, 1'b1);
    for (int i = 0; i < 300; i++) begin
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_bubble_%0d: got in_ready=%b, want 1", i, in_ready);
      end
      step(1'b1, 16'(i * 37 + 5), 2'(i % 4), 1'b1);
      n_checks++;
      if (out_valid !== 1'b1 || model_q.size() != 1 || out_data !== model_q[0]) begin
        n_fail++;
        $display("FAIL b2b_order_%0d: got %b %h, want 1 %h", i, out_valid, out_data, model_q[0]);
      end
    end
    n_checks++;
    if (acc_count !== 8'd44 || model_cnt != 44) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d, want 44", acc_count);
    end
    step(1'b0, 16'h0, 2'b00, 1'b1);
  endtask

  task automatic test_mid_reset();
    step(1'b1, 16'hAAAA, 2'b01, 1'b0);
    step(1'b1, 16'hBBBB, 2'b01, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || acc_count !== 8'h0 || in_ready !== 1'b0 || out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset_async: got v=%b c=%0d r=%b d=%h, want 0 0 0 0",
               out_valid, acc_count, in_ready, out_data);
    end
    model_q.delete();
    model_cnt = 0;
    ready_up = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, 16'h0, 2'b00, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_release: got v=%b r=%b, want 0 1", out_valid, in_ready);
    end
    step(1'b1, 16'h1234, 2'b01, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h00001234 || acc_count !== 8'd1) begin
      n_fail++;
      $display("FAIL midreset_fresh: got %b %h c=%0d, want 1 00001234 1", out_valid, out_data, acc_count);
    end
    step(1'b0, 16'h0, 2'b00, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_no_stale: got valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_narrow();
    longint unsigned r;
    in_valid2 = 1'b1; in_imm2 = 12'h800; in_mode2 = 2'b10; out_ready2 = 1'b1;
    @(posedge clk);
    #1;
    r = model_ext(12, 20, 64'h800, 2);
    n_checks++;
    if (out_valid2 !== 1'b1 || out_data2 !== 20'h80000 || out_data2 !== r[19:0]) begin
      n_fail++;
      $display("FAIL narrow_upper: got %b %h, want 1 80000", out_valid2, out_data2);
    end
    in_mode2 = 2'b00;
    @(posedge clk);
    #1;
    r = model_ext(12, 20, 64'h800, 0);
    n_checks++;
    if (out_valid2 !== 1'b1 || out_data2 !== 20'hFF800 || out_data2 !== r[19:0]) begin
      n_fail++;
      $display("FAIL narrow_sign: got %b %h, want 1 ff800", out_valid2, out_data2);
    end
    in_valid2 = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid2 !== 1'b0 || acc_count2 !== 8'd2) begin
      n_fail++;
      $display("FAIL narrow_drain: got v=%b c=%0d, want 0 2", out_valid2, acc_count2);
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_skid();
    test_random();
    test_narrow();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 16, immediate input width; legal range IN_W >= 2.
REQ-002 SHALL have parameter OUT_W, default 32, extended output width; legal range OUT_W >= IN_W+2.
REQ-003 SHALL have parameter CNT_W, default 8, width of the accepted-transaction counter.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1, upstream has an immediate to offer.
REQ-007 SHALL have port in_ready, output, 1, block can accept an immediate this cycle.
REQ-008 SHALL have port in_imm, input, IN_W, raw immediate field.
REQ-009 SHALL have port in_mode, input, 2, extension mode: 00 sign, 01 zero, 10 upper, 11 branch.
REQ-010 SHALL have port out_valid, output, 1, out_data holds a valid result.
REQ-011 SHALL have port out_ready, input, 1, downstream consumes out_data this cycle.
REQ-012 SHALL have port out_data, output, OUT_W, extended result.
REQ-013 SHALL have port acc_count, output, CNT_W, number of accepted inputs, modulo 2^CNT_W.

Function
REQ-014 SHALL treat an input transfer as in_valid & in_ready high at a rising clk edge.
REQ-015 SHALL treat an output transfer as out_valid & out_ready high at a rising clk edge.
REQ-016 SHALL, in mode 00, replicate in_imm[IN_W-1] into out_data[OUT_W-1:IN_W], with low bits equal to in_imm.
REQ-017 SHALL, in mode 01, fill out_data[OUT_W-1:IN_W] with zeros, with low bits equal to in_imm.
REQ-018 SHALL, in mode 10, output in_imm shifted left by OUT_W-IN_W, with zero low bits.
REQ-019 SHALL, in mode 11, output the mode-00 result shifted left by 2 and truncated to OUT_W bits.
REQ-020 SHALL compute the result combinationally at acceptance and store only the result, not the raw immediate or mode.
REQ-021 SHALL hold results in two storage entries: a main output register and one skid register.
REQ-022 SHALL drive out_data and out_valid from the main register only.
REQ-023 SHALL drive in_ready from a flop, equal to NOT skid_full; there is no combinational path from out_ready to in_ready.
REQ-024 SHALL, on an accepted input when the main register is empty or transferring, load the result into the main register.
REQ-025 SHALL, on an accepted input when the main register is full and not transferring, load the result into skid and set skid_full.
REQ-026 SHALL, on an output transfer while skid_full, move skid into main, clear skid_full, and keep out_valid high.
REQ-027 SHALL, when an output transfer, an input acceptance and skid_full coincide, never occur, because in_ready is 0 whenever skid_full is 1.
REQ-028 SHALL have a latency of 1 cycle: a result accepted at edge N into an empty block shows out_valid=1 after edge N.
REQ-029 SHALL sustain 1 transfer per cycle while out_ready stays 1.
REQ-030 SHALL deliver results in acceptance order, with none dropped or duplicated.
REQ-031 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-032 SHALL increment acc_count by 1 on each input transfer, wrapping from 2^CNT_W-1 to 0.
REQ-033 SHALL ignore in_imm and in_mode whenever no input transfer occurs.

Reset
REQ-034 SHALL, while rst=1, force out_valid=0, out_data=0, skid_full=0, acc_count=0 and in_ready=0, asynchronously.
REQ-035 SHALL raise in_ready to 1 at the first rising clk edge after rst deasserts.
REQ-036 SHALL discard any held results when rst asserts mid-operation.

Verification
REQ-037 SHALL cover: IN_W=16, OUT_W=32, in_imm=16'h8004, each mode, out_ready=1 -> out_data = FFFF8004, 00008004, 80040000, FFFE0010, each 1 cycle after acceptance.
REQ-038 SHALL cover: in_imm=16'h7FFF, mode 00 -> 00007FFF; mode 11 -> 0001FFFC.
REQ-039 SHALL cover: out_ready=0, offer A=0001 then B=0002, both mode 01 -> A held on out_data, B taken into skid, in_ready=0 on the next cycle, a third input stalls; then raise out_ready -> outputs A, B in order, in_ready returns to 1.
REQ-040 SHALL cover: 300 back-to-back accepts with out_ready=1, CNT_W=8 -> acc_count=44, no bubbles, outputs in order.
REQ-041 SHALL cover: assert rst asynchronously between edges with main and skid full -> out_valid=0 and acc_count=0 immediately, and no stale data after release.
REQ-042 SHALL cover: IN_W=12, OUT_W=20, in_imm=12'h800, mode 10 -> out_data=20'h80000; mode 00 -> 20'hFF800.
